// File: rtl/rs232_tx_scheduler_if.sv
// Bundle of producer handshakes, transmitter handshake and status for rs232_tx_scheduler.
interface rs232_tx_scheduler_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic                     iReq0Valid;
  logic [7:0]               iReq0Data;
  logic                     oReq0Ready;
  logic                     iReq1Valid;
  logic [7:0]               iReq1Data;
  logic                     oReq1Ready;
  logic                     oTxStart;
  logic [7:0]               oTxData;
  logic                     iTxBusy;
  logic                     iErrClear;
  logic                     oTxErr;
  logic [FIFO_DEPTH_LOG2:0] oFifoCount;
  logic                     oFifoFull;
  logic                     oFifoEmpty;
  logic                     oIdle;

  // Environment side: producers, transmitter and error-clear source.
  modport master (
    output iReq0Valid, iReq0Data, iReq1Valid, iReq1Data, iTxBusy, iErrClear,
    input  oReq0Ready, oReq1Ready, oTxStart, oTxData, oTxErr,
           oFifoCount, oFifoFull, oFifoEmpty, oIdle
  );

  // Scheduler side.
  modport slave (
    input  iReq0Valid, iReq0Data, iReq1Valid, iReq1Data, iTxBusy, iErrClear,
    output oReq0Ready, oReq1Ready, oTxStart, oTxData, oTxErr,
           oFifoCount, oFifoFull, oFifoEmpty, oIdle
  );
endinterface

// File: rtl/rs232_tx_scheduler.sv
// RS232 transmit scheduler: two-producer arbiter, byte FIFO and start/busy sequencer.
//
// state     | meaning
// S_IDLE    | waiting for a queued byte and a quiet transmitter
// S_START   | oTxStart held, waiting for iTxBusy to rise (bounded by START_TIMEOUT)
// S_WAIT_DONE | transmitter busy with the byte, waiting for iTxBusy to fall
module rs232_tx_scheduler #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int START_TIMEOUT   = 1023
) (
  input  logic                 iCLK,
  input  logic                 Reset,
  rs232_tx_scheduler_if.slave  bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNTW  = FIFO_DEPTH_LOG2 + 1;
  localparam int TW    = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE} state_t;

  state_t                     r_state;
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rptr;
  logic [CNTW-1:0]            r_count;
  logic                       r_prio;
  logic                       r_start;
  logic [7:0]                 r_data;
  logic                       r_err;
  logic [TW-1:0]              r_tmo;

  logic       w_full;
  logic       w_empty;
  logic       w_both;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_push;
  logic [7:0] w_push_data;
  logic       w_pop;
  state_t     w_state_nxt;
  logic       w_start_nxt;
  logic [TW-1:0] w_tmo_nxt;
  logic       w_err_set;

  assign w_full  = (r_count == CNTW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_both  = bus.iReq0Valid & bus.iReq1Valid;

  // Arbiter: full blocks everyone; contention resolved by the rotating priority pointer.
  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (!w_full) begin
      if (w_both) begin
        w_rdy0 = ~r_prio;
        w_rdy1 = r_prio;
      end else begin
        w_rdy0 = bus.iReq0Valid;
        w_rdy1 = bus.iReq1Valid;
      end
    end
  end

  assign w_push      = (bus.iReq0Valid & w_rdy0) | (bus.iReq1Valid & w_rdy1);
  assign w_push_data = (bus.iReq1Valid & w_rdy1) ? bus.iReq1Data : bus.iReq0Data;

  // Sequencer next state: dispatch from IDLE, bounded start handshake, wait for frame end.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = r_start;
    w_tmo_nxt   = r_tmo;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && !bus.iTxBusy) begin
          w_pop       = 1'b1;
          w_start_nxt = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (bus.iTxBusy) begin
          w_start_nxt = 1'b0;
          w_state_nxt = S_WAIT_DONE;
        end else if (r_tmo == TW'(START_TIMEOUT)) begin
          w_start_nxt = 1'b0;
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.iTxBusy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state register and registered transmitter outputs; timeout error is sticky.
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_data  <= 8'h00;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_start_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_pop) r_data <= r_mem[r_rptr];
      if (w_err_set)          r_err <= 1'b1;
      else if (bus.iErrClear) r_err <= 1'b0;
    end
  end

  // FIFO pointers, occupancy and arbitration priority.
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_prio  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_push && w_both) r_prio <= ~r_prio;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge iCLK) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  assign bus.oReq0Ready = w_rdy0;
  assign bus.oReq1Ready = w_rdy1;
  assign bus.oTxStart   = r_start;
  assign bus.oTxData    = r_data;
  assign bus.oTxErr     = r_err;
  assign bus.oFifoCount = r_count;
  assign bus.oFifoFull  = w_full;
  assign bus.oFifoEmpty = w_empty;
  assign bus.oIdle      = (r_state == S_IDLE) & w_empty;
endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// Self-checking bench for rs232_tx_scheduler: arbiter vector table, directed
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_rs232_tx_scheduler;
  localparam int LOG2  = 4;
  localparam int DEPTH = 16;
  localparam int TO    = 7;

  logic iCLK  = 1'b0;
  logic Reset = 1'b1;
  always #5 iCLK = ~iCLK;

  rs232_tx_scheduler_if #(.FIFO_DEPTH_LOG2(LOG2)) bus ();
  rs232_tx_scheduler #(.FIFO_DEPTH_LOG2(LOG2), .START_TIMEOUT(TO)) dut (
    .iCLK (iCLK),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  // Transmitter model: mode 0 = busy forced from busy_force, 1 = fixed delay/hold, 2 = random.
  int   tx_mode    = 0;
  logic busy_force = 1'b0;
  int   tx_dly     = 0;
  int   tx_hold    = 1;
  logic model_busy = 1'b0;
  int   tx_wait    = -1;
  int   tx_left    = 0;
  assign bus.iTxBusy = (tx_mode == 0) ? busy_force : model_busy;

  always @(negedge iCLK) begin
    if (tx_mode == 0) begin
      model_busy = 1'b0;
      tx_wait    = -1;
    end else if (model_busy) begin
      tx_left--;
      if (tx_left <= 0) model_busy = 1'b0;
    end else if (bus.oTxStart) begin
      if (tx_wait < 0) tx_wait = (tx_mode == 2) ? int'($urandom_range(0, 5)) : tx_dly;
      if (tx_wait == 0) begin
        model_busy = 1'b1;
        tx_left    = (tx_mode == 2) ? int'($urandom_range(1, 8)) : tx_hold;
        tx_wait    = -1;
      end else begin
        tx_wait--;
      end
    end
  end

  // Start monitor: bytes captured at each oTxStart rise, and total cycles oTxStart is high.
  logic       mon_prev = 1'b0;
  logic [7:0] sent_q[$];
  int         start_hi_cnt = 0;
  always @(negedge iCLK) begin
    if (bus.oTxStart === 1'b1) begin
      start_hi_cnt++;
      if (!mon_prev) sent_q.push_back(bus.oTxData);
    end
    mon_prev = bus.oTxStart;
  end

  // Reference model: occupancy, priority pointer and the expected transmit order.
  int         m_count;
  logic       m_prio;
  logic [7:0] exp_q[$];
  logic       m_prev_start;
  logic [7:0] seq;

  task automatic do_reset();
    Reset = 1'b1;
    bus.iReq0Valid = 1'b0;
    bus.iReq1Valid = 1'b0;
    bus.iErrClear  = 1'b0;
    tx_mode    = 0;
    busy_force = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    sent_q.delete();
    exp_q.delete();
    start_hi_cnt = 0;
    m_count      = 0;
    m_prio       = 1'b0;
    m_prev_start = 1'b0;
  endtask

  // mode 0: random valids/data, mode 1: req0 always valid with a sequence, mode 2: no traffic.
  task automatic run_model(input int cycles, input int mode);
    logic v0, v1, e0, e1;
    logic [7:0] d0, d1;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (bus.oTxStart && !m_prev_start) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL dispatch: start with empty model queue, data=%0h", bus.oTxData);
        end else begin
          check("dispatch_order", bus.oTxData, exp_q.pop_front());
          m_count--;
        end
      end
      m_prev_start = bus.oTxStart;
      check("model_count", bus.oFifoCount, m_count);
      check("model_full", bus.oFifoFull, m_count == DEPTH);
      check("model_empty", bus.oFifoEmpty, m_count == 0);
      check("model_err", bus.oTxErr, 0);
      case (mode)
        0: begin v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1)); end
        1: begin v0 = 1'b1; v1 = 1'b0; end
        default: begin v0 = 1'b0; v1 = 1'b0; end
      endcase
      d0 = (mode == 1) ? seq : 8'($urandom);
      d1 = 8'($urandom);
      bus.iReq0Valid = v0;
      bus.iReq0Data  = d0;
      bus.iReq1Valid = v1;
      bus.iReq1Data  = d1;
      #1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (m_count < DEPTH) begin
        if (v0 && v1) begin
          if (m_prio) e1 = 1'b1;
          else        e0 = 1'b1;
        end else begin
          e0 = v0;
          e1 = v1;
        end
      end
      check("model_rdy0", bus.oReq0Ready, e0);
      check("model_rdy1", bus.oReq1Ready, e1);
      if (e0) begin
        exp_q.push_back(d0);
        m_count++;
        if (mode == 1) seq++;
      end else if (e1) begin
        exp_q.push_back(d1);
        m_count++;
      end
      if (v0 && v1 && (e0 || e1)) m_prio = ~m_prio;
    end
  endtask

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    int         cnt;
  } arb_vec_t;

  initial begin
    arb_vec_t vecs[8];
    int n0, n1, c;
    logic e0, e1;

    bus.iReq0Valid = 1'b0;
    bus.iReq0Data  = 8'h00;
    bus.iReq1Valid = 1'b0;
    bus.iReq1Data  = 8'h00;
    bus.iErrClear  = 1'b0;

    // Arbiter table, from empty FIFO with priority on requester 0 and transmitter held busy.
    vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h20, 1'b0, 1'b1, 2};
    vecs[3] = '{1'b1, 1'b1, 8'h11, 8'h21, 1'b1, 1'b0, 3};
    vecs[4] = '{1'b1, 1'b1, 8'h12, 8'h22, 1'b0, 1'b1, 4};
    vecs[5] = '{1'b1, 1'b0, 8'h13, 8'h00, 1'b1, 1'b0, 5};
    vecs[6] = '{1'b1, 1'b1, 8'h14, 8'h23, 1'b1, 1'b0, 6};
    vecs[7] = '{1'b1, 1'b1, 8'h15, 8'h24, 1'b0, 1'b1, 7};

    // Reset state
    do_reset();
    check("rst_count", bus.oFifoCount, 0);
    check("rst_empty", bus.oFifoEmpty, 1);
    check("rst_full", bus.oFifoFull, 0);
    check("rst_idle", bus.oIdle, 1);
    check("rst_start", bus.oTxStart, 0);
    check("rst_data", bus.oTxData, 8'h00);
    check("rst_err", bus.oTxErr, 0);
    bus.iReq0Valid = 1'b1;
    #1;
    check("rst_rdy0_follows", bus.oReq0Ready, 1);
    check("rst_rdy1_follows", bus.oReq1Ready, 0);
    bus.iReq0Valid = 1'b0;

    // Arbiter vector table
    do_reset();
    busy_force = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.iReq0Valid = vecs[i].v0;
      bus.iReq0Data  = vecs[i].d0;
      bus.iReq1Valid = vecs[i].v1;
      bus.iReq1Data  = vecs[i].d1;
      #1;
      check("vec_rdy0", bus.oReq0Ready, vecs[i].r0);
      check("vec_rdy1", bus.oReq1Ready, vecs[i].r1);
      tick();
      bus.iReq0Valid = 1'b0;
      bus.iReq1Valid = 1'b0;
      check("vec_count", bus.oFifoCount, vecs[i].cnt);
    end
    check("vec_no_start_while_busy", start_hi_cnt, 0);

    // Single byte on req0, transmitter busy 3 cycles after start for 20 cycles
    do_reset();
    tx_mode = 1; tx_dly = 3; tx_hold = 20;
    tick();
    bus.iReq0Valid = 1'b1;
    bus.iReq0Data  = 8'h41;
    #1;
    check("t1_rdy0", bus.oReq0Ready, 1);
    tick();
    bus.iReq0Valid = 1'b0;
    check("t1_count_after_push", bus.oFifoCount, 1);
    check("t1_no_bypass", bus.oTxStart, 0);
    tick();
    check("t1_start", bus.oTxStart, 1);
    check("t1_data", bus.oTxData, 8'h41);
    for (c = 0; c < 60 && !(sent_q.size() == 1 && bus.oIdle && !bus.iTxBusy); c++) tick();
    check("t1_completed", c < 60, 1);
    check("t1_start_len", start_hi_cnt, 4);
    check("t1_sent_cnt", sent_q.size(), 1);
    if (sent_q.size() > 0) check("t1_sent_byte", sent_q[0], 8'h41);
    check("t1_idle", bus.oIdle, 1);

    // Both requesters valid continuously until full: A0,B0,A1,B1,...
    do_reset();
    busy_force = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.iReq0Valid = 1'b1;
      bus.iReq1Valid = 1'b1;
      bus.iReq0Data  = 8'hA0 + 8'(n0);
      bus.iReq1Data  = 8'hB0 + 8'(n1);
      #1;
      e0 = (i < DEPTH) && (i % 2 == 0);
      e1 = (i < DEPTH) && (i % 2 == 1);
      check("fill_rdy0", bus.oReq0Ready, e0);
      check("fill_rdy1", bus.oReq1Ready, e1);
      if (e0) begin exp_q.push_back(8'hA0 + 8'(n0)); n0++; end
      if (e1) begin exp_q.push_back(8'hB0 + 8'(n1)); n1++; end
    end
    check("fill_full", bus.oFifoFull, 1);
    check("fill_count", bus.oFifoCount, DEPTH);

    // Drain while req0 pushes continuously: push/pop at full and wrap with order kept
    m_count = DEPTH;
    m_prio = 1'b0;
    m_prev_start = 1'b0;
    seq = 8'h00;
    tx_mode = 1; tx_dly = 0; tx_hold = 1;
    run_model(90, 1);
    run_model(120, 2);
    check("wrap_all_sent", exp_q.size(), 0);
    check("wrap_over_40", 32'(seq) + 16 >= 40, 1);
    check("wrap_idle", bus.oIdle, 1);

    // Start timeout: transmitter never responds
    do_reset();
    busy_force = 1'b0;
    tick();
    bus.iReq0Valid = 1'b1;
    bus.iReq0Data  = 8'h11;
    tick();
    bus.iReq0Data  = 8'h22;
    tick();
    bus.iReq0Valid = 1'b0;
    for (c = 0; c < 40 && !bus.oTxErr; c++) tick();
    check("to_err_set", bus.oTxErr, 1);
    check("to_start_low", bus.oTxStart, 0);
    check("to_start_len", start_hi_cnt, TO + 1);
    for (c = 0; c < 40 && sent_q.size() < 2; c++) tick();
    check("to_next_dispatched", sent_q.size(), 2);
    if (sent_q.size() > 1) check("to_next_byte", sent_q[1], 8'h22);
    check("to_err_sticky", bus.oTxErr, 1);
    for (c = 0; c < 40 && !bus.oIdle; c++) tick();
    check("to_idle", bus.oIdle, 1);
    bus.iErrClear = 1'b1;
    tick();
    bus.iErrClear = 1'b0;
    check("to_err_cleared", bus.oTxErr, 0);

    // Busy held high with three bytes queued, then released
    do_reset();
    busy_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.iReq1Valid = 1'b1;
      bus.iReq1Data  = 8'h31 + 8'(i);
    end
    tick();
    bus.iReq1Valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bh_no_start", start_hi_cnt, 0);
    check("bh_count", bus.oFifoCount, 3);
    tx_mode = 1; tx_dly = 2; tx_hold = 4;
    for (c = 0; c < 80 && !(sent_q.size() == 3 && bus.oIdle); c++) tick();
    check("bh_sent_cnt", sent_q.size(), 3);
    for (int i = 0; i < 3 && i < sent_q.size(); i++) check("bh_order", sent_q[i], 8'h31 + 8'(i));

    // Reset during WAIT_DONE with five bytes queued
    do_reset();
    tx_mode = 1; tx_dly = 1; tx_hold = 30;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.iReq0Valid = 1'b1;
      bus.iReq0Data  = 8'h61 + 8'(i);
    end
    tick();
    bus.iReq0Valid = 1'b0;
    for (c = 0; c < 20 && !(bus.iTxBusy && !bus.oTxStart); c++) tick();
    check("rw_in_wait_done", bus.iTxBusy && !bus.oTxStart, 1);
    check("rw_queued", bus.oFifoCount, 5);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rw_count", bus.oFifoCount, 0);
    check("rw_start", bus.oTxStart, 0);
    check("rw_idle", bus.oIdle, 1);
    for (int i = 0; i < 50; i++) tick();
    check("rw_no_more_starts", sent_q.size(), 1);

    // Randomized traffic against the reference model
    do_reset();
    tx_mode = 2;
    run_model(600, 0);
    run_model(400, 2);
    check("rand_all_sent", exp_q.size(), 0);
    check("rand_idle", bus.oIdle, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
